pellet_tracker: RTL

- Holds the eaten/uneaten state of every pellet on a 40x30 grid of 16x16-pixel tiles covering the 640x480 screen.
- Once per frame it checks the tile under the pacman centre (BallX/BallY from the ball stage) and clears that pellet if it is present.
- Per pixel it answers "draw a pellet dot here?" for DrawX/DrawY, feeding color_mapper.
- Also keeps the eaten count and remaining count that the top level shows on HEX/LED.

---
 rtl/pellet_tracker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pellet_tracker.sv
// Pellet bitmap for a 40x30 tile grid: refill sweep, once-per-frame eat at the
// pacman tile, per-pixel dot lookup for the colour mapper, eaten/remaining counters.
module pellet_tracker #(
    parameter int TILE_SHIFT = 4,
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int DOT_LO     = 6,
    parameter int DOT_HI     = 9
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        restart,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        pellet_on,
    output logic [10:0] eaten,
    output logic [10:0] remaining,
    output logic        all_eaten,
    output logic        busy
);

    localparam int                    NPEL   = COLS * ROWS;
    localparam logic [10:0]           P_LAST = 11'(NPEL - 1);
    localparam logic [10:0]           P_NPEL = 11'(NPEL);
    localparam logic [9:0]            P_XMAX = 10'(COLS << TILE_SHIFT);
    localparam logic [9:0]            P_YMAX = 10'(ROWS << TILE_SHIFT);
    localparam logic [TILE_SHIFT-1:0] P_LO   = TILE_SHIFT'(DOT_LO);
    localparam logic [TILE_SHIFT-1:0] P_HI   = TILE_SHIFT'(DOT_HI);

    typedef enum logic [1:0] {S_FILL, S_IDLE, S_READ, S_EAT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_fill_addr;
    logic [10:0] r_eaten;
    logic [10:0] r_remaining;
    logic        r_fs1, r_fs2, r_fs3;
    logic [5:0]  r_col, r_row;
    logic        r_rd_bit;
    logic        r_dot_bit;
    logic        r_dot_ok;
    logic        r_mem [0:NPEL-1];

    logic        w_frame_pulse;
    logic        w_ball_ok;
    logic [10:0] w_addr_a;
    logic [10:0] w_addr_b;
    logic        w_we;
    logic [10:0] w_waddr;
    logic        w_wdata;
    logic        w_draw_in;
    logic        w_offs_ok;

    // The constant COLS=40 multiply is folded into two shifts and an add.
    function automatic logic [10:0] tile_addr(input logic [5:0] row, input logic [5:0] col);
        logic [10:0] w_r;
        w_r = 11'(row);
        return (w_r << 5) + (w_r << 3) + 11'(col);
    endfunction

    assign w_frame_pulse = r_fs2 & ~r_fs3;
    assign w_ball_ok     = (BallX < P_XMAX) && (BallY < P_YMAX);
    assign w_addr_a      = tile_addr(r_row, r_col);
    assign w_addr_b      = tile_addr(6'(DrawY >> TILE_SHIFT), 6'(DrawX >> TILE_SHIFT));
    assign w_draw_in     = (DrawX < P_XMAX) && (DrawY < P_YMAX);
    assign w_offs_ok     = (DrawX[TILE_SHIFT-1:0] >= P_LO) && (DrawX[TILE_SHIFT-1:0] <= P_HI) &&
                           (DrawY[TILE_SHIFT-1:0] >= P_LO) && (DrawY[TILE_SHIFT-1:0] <= P_HI);

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = w_addr_a;
        w_wdata     = 1'b0;
        case (r_state)
            S_FILL: begin
                w_we    = 1'b1;
                w_waddr = r_fill_addr;
                w_wdata = 1'b1;
                if (r_fill_addr == P_LAST) w_state_nxt = S_IDLE;
            end
            S_IDLE: if (w_frame_pulse && w_ball_ok) w_state_nxt = S_READ;
            S_READ: w_state_nxt = S_EAT;
            S_EAT: begin
                w_we        = r_rd_bit;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_FILL;
        endcase
        // Restart overrides everything, including a pending eat write.
        if (restart) begin
            w_state_nxt = S_FILL;
            w_we        = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_FILL;
            r_fill_addr <= '0;
            r_eaten     <= '0;
            r_remaining <= '0;
            r_fs1       <= 1'b0;
            r_fs2       <= 1'b0;
            r_fs3       <= 1'b0;
            r_dot_ok    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fs1    <= frame_clk;
            r_fs2    <= r_fs1;
            r_fs3    <= r_fs2;
            r_dot_ok <= w_draw_in && w_offs_ok && (r_state != S_FILL);
            if (restart) begin
                r_fill_addr <= '0;
                r_eaten     <= '0;
                r_remaining <= '0;
            end else if (r_state == S_FILL) begin
                r_fill_addr <= r_fill_addr + 11'd1;
                if (r_fill_addr == P_LAST) r_remaining <= P_NPEL;
            end else if (r_state == S_EAT && r_rd_bit) begin
                r_eaten     <= r_eaten + 11'd1;
                r_remaining <= r_remaining - 11'd1;
            end
        end
    end

    // Bitmap and its read registers carry no reset; the FILL sweep initialises them.
    always_ff @(posedge Clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rd_bit  <= r_mem[w_addr_a];
        r_dot_bit <= w_draw_in ? r_mem[w_addr_b] : 1'b0;
        if (r_state == S_IDLE && w_frame_pulse) begin
            r_col <= 6'(BallX >> TILE_SHIFT);
            r_row <= 6'(BallY >> TILE_SHIFT);
        end
    end

    assign pellet_on = r_dot_bit & r_dot_ok;
    assign eaten     = r_eaten;
    assign remaining = r_remaining;
    assign busy      = (r_state == S_FILL);
    assign all_eaten = (r_remaining == 11'd0) && !busy;

endmodule
